am_similarity_accumulator: RTL and testbench

Upstream stage of the associative-memory (AM) classifier. Streams a sparse query hypervector in CHUNK_W-bit chunks and, per chunk, reads the matching chunk of each of the 26 class hypervectors from the external AM ROM. Accumulates popcount(query & class) per class into 26 SIM_W-bit similarity registers. After the last chunk, pulses `inferring_class` and holds `similarity_values` for the downstream tree comparator.

---
 rtl/am_pkg.sv | 23 ++
 rtl/am_popcount.sv | 43 ++++
 rtl/am_similarity_accumulator.sv | 199 +++++++++++++++++++
 tb/tb_am_similarity_accumulator.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/am_pkg.sv
// ---------------------------------------------------------------------------
// am_pkg
//   Shared definitions for the associative-memory classifier: class count,
//   default similarity width, class-index width, similarity type and the
//   accumulator FSM encoding.  Also imported by the downstream tree comparator.
// ---------------------------------------------------------------------------
package am_pkg;

  localparam int unsigned NUM_CLASSES = 26;
  localparam int unsigned SIM_W       = 13;
  localparam int unsigned CLASS_W     = 5;

  typedef logic [SIM_W-1:0] sim_t;

  typedef enum logic [2:0] {
    IDLE,
    ACCEPT,
    SCAN,
    DRAIN,
    DONE
  } am_acc_state_e;

endpackage

// File: rtl/am_popcount.sv
// ---------------------------------------------------------------------------
// am_popcount
//   Purely combinational population count built as a balanced binary adder
//   tree.  The input is padded with zeros up to the next power of two.
//
// Parameters:
//   WIDTH    number of input bits
// Ports:
//   i_bits   [WIDTH-1:0]            bits to count
//   o_count  [$clog2(WIDTH+1)-1:0]  number of ones in i_bits
// ---------------------------------------------------------------------------
module am_popcount #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0]               i_bits,
  output logic [$clog2(WIDTH+1)-1:0]     o_count
);

  localparam int unsigned OUT_W  = $clog2(WIDTH + 1);
  localparam int unsigned LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned LEAVES = 1 << LEVELS;

  logic [LEAVES-1:0] w_pad;

  assign w_pad = LEAVES'(i_bits);

  // Heap-ordered tree: node n has children 2n+1 and 2n+2, leaves occupy
  // indices LEAVES-1 .. 2*LEAVES-2, root is node 0.
  always_comb begin
    logic [OUT_W-1:0] node [0:2*LEAVES-2];
    for (int unsigned n = 0; n < 2*LEAVES-1; n++) begin
      node[n] = '0;
    end
    for (int unsigned i = 0; i < LEAVES; i++) begin
      node[LEAVES-1+i] = OUT_W'(w_pad[i]);
    end
    for (int unsigned i = LEAVES-1; i > 0; i--) begin
      node[i-1] = node[2*i-1] + node[2*i];
    end
    o_count = node[0];
  end

endmodule

// File: rtl/am_similarity_accumulator.sv
// ---------------------------------------------------------------------------
// am_similarity_accumulator
//   Streams a query hypervector chunk by chunk, reads the matching chunk of
//   every class hypervector from the AM ROM and accumulates
//   popcount(query & class) per class.  After the last chunk it pulses
//   inferring_class with the similarity values final and held.
//
// Build option:
//   SIM_SATURATE_EN  defined: accumulators clamp at 2^SIM_W-1
//                    undefined: accumulators wrap modulo 2^SIM_W
//
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   start              pulse: clear accumulators and begin a query (IDLE only)
//   q_valid/q_ready    query chunk handshake; q_ready depends on state only
//   q_chunk            query chunk, index 0 first
//   mem_rd_en          ROM read strobe; data returns one cycle later
//   mem_chunk_addr     ROM chunk index
//   mem_class_addr     ROM class index
//   mem_rd_data        ROM read data
//   similarity_values  per-class accumulated similarity
//   inferring_class    one-cycle pulse: results final
//   busy               high from accepted start through the result pulse
// ---------------------------------------------------------------------------
module am_similarity_accumulator #(
  parameter int unsigned NUM_CLASSES = 26,
  parameter int unsigned CHUNK_W     = 64,
  parameter int unsigned NUM_CHUNKS  = 79,
  parameter int unsigned SIM_W       = 13
) (
  input  logic                            clk,
  input  logic                            nrst,
  input  logic                            start,
  input  logic                            q_valid,
  output logic                            q_ready,
  input  logic [CHUNK_W-1:0]              q_chunk,
  output logic                            mem_rd_en,
  output logic [$clog2(NUM_CHUNKS)-1:0]   mem_chunk_addr,
  output logic [am_pkg::CLASS_W-1:0]      mem_class_addr,
  input  logic [CHUNK_W-1:0]              mem_rd_data,
  output logic [SIM_W-1:0]                similarity_values [0:NUM_CLASSES-1],
  output logic                            inferring_class,
  output logic                            busy
);

  import am_pkg::*;

  localparam int unsigned CHK_W = $clog2(NUM_CHUNKS);
  localparam int unsigned PC_W  = $clog2(CHUNK_W + 1);

  localparam logic [CLASS_W-1:0] LAST_CLASS = CLASS_W'(NUM_CLASSES - 1);
  localparam logic [CHK_W-1:0]   LAST_CHUNK = CHK_W'(NUM_CHUNKS - 1);

  am_acc_state_e r_state;
  am_acc_state_e w_next;

  logic [CHK_W-1:0]   r_chunk;
  logic [CLASS_W-1:0] r_class;
  logic [CHUNK_W-1:0] r_q;
  logic               r_rd_d;
  logic [CLASS_W-1:0] r_class_d;
  logic [SIM_W-1:0]   r_acc [0:NUM_CLASSES-1];

  logic               w_clear;
  logic               w_take;
  logic [CHUNK_W-1:0] w_and;
  logic [PC_W-1:0]    w_pop;
  logic [SIM_W-1:0]   w_cur;
  logic [SIM_W-1:0]   w_acc_next;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next          = r_state;
    q_ready         = 1'b0;
    mem_rd_en       = 1'b0;
    inferring_class = 1'b0;
    w_clear         = 1'b0;
    w_take          = 1'b0;
    busy            = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = ACCEPT;
        end
      end
      ACCEPT: begin
        q_ready = 1'b1;
        if (q_valid) begin
          w_take = 1'b1;
          w_next = SCAN;
        end
      end
      SCAN: begin
        mem_rd_en = 1'b1;
        if (r_class == LAST_CLASS) begin
          w_next = DRAIN;
        end
      end
      DRAIN: begin
        w_next = (r_chunk == LAST_CHUNK) ? DONE : ACCEPT;
      end
      DONE: begin
        inferring_class = 1'b1;
        w_next          = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign mem_chunk_addr = r_chunk;
  assign mem_class_addr = r_class;

  // -------------------------------------------------------------------------
  // Counters, query register and read-return pipeline
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_chunk   <= '0;
      r_class   <= '0;
      r_q       <= '0;
      r_rd_d    <= 1'b0;
      r_class_d <= '0;
    end else begin
      r_rd_d    <= mem_rd_en;
      r_class_d <= r_class;

      if (w_clear) begin
        r_chunk <= '0;
      end else if (r_state == DRAIN && r_chunk != LAST_CHUNK) begin
        r_chunk <= r_chunk + 1'b1;
      end

      // Class counter wraps to 0 after the last issue so the address bus
      // idles at 0 outside SCAN.
      if (w_take) begin
        r_q     <= q_chunk;
        r_class <= '0;
      end else if (r_state == SCAN) begin
        r_class <= (r_class == LAST_CLASS) ? '0 : r_class + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Single shared popcount + adder; the result is steered to the class whose
  // read was issued in the previous cycle.
  // -------------------------------------------------------------------------
  assign w_and = r_q & mem_rd_data;

  am_popcount #(
    .WIDTH (CHUNK_W)
  ) u_popcount (
    .i_bits  (w_and),
    .o_count (w_pop)
  );

  assign w_cur = r_acc[r_class_d];

`ifdef SIM_SATURATE_EN
  logic [SIM_W:0] w_wide;

  assign w_wide     = {1'b0, w_cur} + (SIM_W+1)'(w_pop);
  assign w_acc_next = w_wide[SIM_W] ? '1 : w_wide[SIM_W-1:0];
`else
  assign w_acc_next = w_cur + SIM_W'(w_pop);
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        r_acc[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_CLASSES; k++) begin
        if (w_clear) begin
          r_acc[k] <= '0;
        end else if (r_rd_d && r_class_d == CLASS_W'(k)) begin
          r_acc[k] <= w_acc_next;
        end
      end
    end
  end

  assign similarity_values = r_acc;

endmodule

// File: tb/tb_am_similarity_accumulator.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_am_similarity_accumulator
//   Two instances run in lockstep on the same query stream: the default
//   SIM_W=13 build and a narrow SIM_W=8 build that exercises wrap/saturation.
//   Each has its own ROM model answering one cycle after its read strobe.
//   Expected similarities come from a $countones reference model and are
//   queued when a query is launched, then popped at the result pulse.
// ---------------------------------------------------------------------------
module tb_am_similarity_accumulator;

  localparam int unsigned NCL      = 26;
  localparam int unsigned CW       = 64;
  localparam int unsigned NCH      = 79;
  localparam int unsigned SW1      = 13;
  localparam int unsigned SW2      = 8;
  localparam int unsigned BASE_LAT = NCH * 28 + 1;
  localparam int unsigned NO_POKE  = 9999;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            start = 1'b0;
  logic            q_valid = 1'b0;
  logic [CW-1:0]   q_chunk = '0;

  logic            q_ready1, rd_en1, inf1, busy1;
  logic [6:0]      chk_a1;
  logic [4:0]      cls_a1;
  logic [CW-1:0]   rd_data1;
  logic [SW1-1:0]  sim1 [0:NCL-1];

  logic            q_ready2, rd_en2, inf2, busy2;
  logic [6:0]      chk_a2;
  logic [4:0]      cls_a2;
  logic [CW-1:0]   rd_data2;
  logic [SW2-1:0]  sim2 [0:NCL-1];

  int unsigned     rom_mode = 0;
  logic [CW-1:0]   q_mem [0:NCH-1];
  int unsigned     cyc = 0;
  int unsigned     pulses = 0;
  int unsigned     n_assert = 0;
  int unsigned     n_fail = 0;

  typedef struct packed {
    logic [NCL-1:0][SW1-1:0] s1;
    logic [NCL-1:0][SW2-1:0] s2;
    logic [31:0]             lat;
  } exp_t;

  exp_t exp_q[$];

  am_similarity_accumulator u_dut1 (
    .clk               (clk),
    .nrst              (nrst),
    .start             (start),
    .q_valid           (q_valid),
    .q_ready           (q_ready1),
    .q_chunk           (q_chunk),
    .mem_rd_en         (rd_en1),
    .mem_chunk_addr    (chk_a1),
    .mem_class_addr    (cls_a1),
    .mem_rd_data       (rd_data1),
    .similarity_values (sim1),
    .inferring_class   (inf1),
    .busy              (busy1)
  );

  am_similarity_accumulator #(
    .SIM_W (SW2)
  ) u_dut2 (
    .clk               (clk),
    .nrst              (nrst),
    .start             (start),
    .q_valid           (q_valid),
    .q_ready           (q_ready2),
    .q_chunk           (q_chunk),
    .mem_rd_en         (rd_en2),
    .mem_chunk_addr    (chk_a2),
    .mem_class_addr    (cls_a2),
    .mem_rd_data       (rd_data2),
    .similarity_values (sim2),
    .inferring_class   (inf2),
    .busy              (busy2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (inf1) pulses <= pulses + 1;

  // mode 0: class k chunk = k ones in the LSBs; mode 1: all ones;
  // otherwise a hashed pattern of (class, chunk).
  function automatic logic [CW-1:0] rom_word(input int unsigned mode,
                                             input int unsigned cls,
                                             input int unsigned chk);
    logic [CW-1:0] one;
    logic [31:0]   a, b;
    one = 64'd1;
    case (mode)
      0: return (one << cls) - one;
      1: return '1;
      default: begin
        a = (cls * 32'h9E3779B1) ^ ((chk + 1) * 32'h85EBCA6B);
        b = (a ^ (a >> 15)) * 32'h2C1B3C6D;
        return {a ^ b, b};
      end
    endcase
  endfunction

  always @(posedge clk) begin
    rd_data1 <= rom_word(rom_mode, 32'(cls_a1), 32'(chk_a1));
    rd_data2 <= rom_word(rom_mode, 32'(cls_a2), 32'(chk_a2));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, observed no end, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_expected(input int unsigned stall);
    exp_t        e;
    int unsigned a1, a2, p;
    e = '0;
    for (int unsigned k = 0; k < NCL; k++) begin
      a1 = 0;
      a2 = 0;
      for (int unsigned c = 0; c < NCH; c++) begin
        p = $countones(q_mem[c] & rom_word(rom_mode, k, c));
`ifdef SIM_SATURATE_EN
        a1 = (a1 + p > 8191) ? 8191 : a1 + p;
        a2 = (a2 + p > 255)  ? 255  : a2 + p;
`else
        a1 = (a1 + p) % 8192;
        a2 = (a2 + p) % 256;
`endif
      end
      e.s1[k] = SW1'(a1);
      e.s2[k] = SW2'(a2);
    end
    e.lat = BASE_LAT + NCH * stall;
    exp_q.push_back(e);
  endtask

  // Presents chunk c: optionally idles q_valid for `stall` ready cycles,
  // then holds q_valid until the handshake is seen.
  task automatic feed_chunk(input int unsigned c, input int unsigned stall, output bit ok);
    int unsigned guard;
    bit          rdy;
    ok = 1'b1;
    if (stall != 0) begin
      q_valid = 1'b0;
      guard = 0;
      rdy = 1'b0;
      while (!rdy && guard < 100) begin
        @(negedge clk);
        rdy = q_ready1;
        if (!rdy) begin
          @(posedge clk); #1;
          guard++;
        end
      end
      if (!rdy) ok = 1'b0;
      repeat (stall) begin
        @(posedge clk); #1;
      end
    end
    q_valid = 1'b1;
    q_chunk = q_mem[c];
    guard = 0;
    rdy = 1'b0;
    while (!rdy && guard < 100) begin
      @(negedge clk);
      rdy = q_ready1;
      @(posedge clk); #1;
      guard++;
    end
    if (!rdy) ok = 1'b0;
  endtask

  task automatic run_query(input string name, input int unsigned stall, input int unsigned poke);
    int unsigned t_ready, guard, p0;
    bit          ok;
    exp_t        e;
    push_expected(stall);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({name, " q_ready 1 cycle after start"}, q_ready1, 1);
    check({name, " busy after start"}, busy1, 1);
    check({name, " sim cleared by start"}, sim1[NCL-1], 0);
    t_ready = cyc;
    p0 = pulses;
    for (int unsigned c = 0; c < NCH; c++) begin
      feed_chunk(c, stall, ok);
      if (!ok) begin
        check({name, " chunk accepted in time"}, ok, 1);
        break;
      end
      if (c == poke) begin
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    q_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!inf1 && guard < 400);
    e = exp_q.pop_front();
    check({name, " result pulse seen"}, inf1, 1);
    if (inf1) begin
      // Inclusive cycle count from the first q_ready cycle to the pulse cycle.
      check({name, " latency"}, cyc - t_ready + 1, e.lat);
      check({name, " busy at pulse"}, busy1, 1);
      check({name, " narrow pulse aligned"}, inf2, 1);
      for (int unsigned k = 0; k < NCL; k++) begin
        check($sformatf("%s sim13[%0d]", name, k), sim1[k], e.s1[k]);
        check($sformatf("%s sim8[%0d]", name, k), sim2[k], e.s2[k]);
      end
      @(negedge clk);
      check({name, " pulse one cycle"}, inf1, 0);
      check({name, " busy drops after pulse"}, busy1, 0);
      check({name, " single pulse"}, pulses - p0, 1);
      check({name, " result held"}, sim1[NCL-1], e.s1[NCL-1]);
    end
  endtask

  initial begin
    bit ok;
    int unsigned p0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset q_ready", q_ready1, 0);
    check("reset mem_rd_en", rd_en1, 0);
    check("reset inferring_class", inf1, 0);
    check("reset busy", busy1, 0);
    check("reset chunk addr", chk_a1, 0);
    check("reset class addr", cls_a1, 0);
    check("reset sim13[0]", sim1[0], 0);
    check("reset sim13[25]", sim1[NCL-1], 0);
    check("reset sim8[25]", sim2[NCL-1], 0);
    nrst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // A: all-ones query, class k has k ones -> 79*k
    rom_mode = 0;
    for (int unsigned c = 0; c < NCH; c++) q_mem[c] = '1;
    run_query("A", 0, NO_POKE);

    // B: zero query against all-ones ROM
    rom_mode = 1;
    for (int unsigned c = 0; c < NCH; c++) q_mem[c] = '0;
    run_query("B", 0, NO_POKE);

    // C: same as A with 5 stall cycles before each chunk
    rom_mode = 0;
    for (int unsigned c = 0; c < NCH; c++) q_mem[c] = '1;
    run_query("C", 5, NO_POKE);

    // D: pseudo-random query and ROM, plain then with start during SCAN of chunk 3
    rom_mode = 2;
    for (int unsigned c = 0; c < NCH; c++) q_mem[c] = {$urandom, $urandom};
    run_query("D1", 0, NO_POKE);
    run_query("D2", 0, 3);

    // E: all-ones query and ROM -> 5056; narrow build wraps to 192 or clamps at 255
    rom_mode = 1;
    for (int unsigned c = 0; c < NCH; c++) q_mem[c] = '1;
    run_query("E", 0, NO_POKE);

    // F: reset in the middle of SCAN, chunk 10 class 7
    rom_mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ok = 1'b1;
    for (int unsigned c = 0; c <= 10; c++) begin
      feed_chunk(c, 0, ok);
      if (!ok) break;
    end
    check("F chunk 10 accepted", ok, 1);
    q_valid = 1'b0;
    repeat (7) begin
      @(posedge clk); #1;
    end
    check("F class addr before reset", cls_a1, 7);
    check("F chunk addr before reset", chk_a1, 10);
    check("F partial sim13[25]", sim1[NCL-1], 250);
    #2;
    nrst = 1'b0;
    #1;
    check("F async q_ready", q_ready1, 0);
    check("F async mem_rd_en", rd_en1, 0);
    check("F async busy", busy1, 0);
    check("F async inferring_class", inf1, 0);
    check("F async chunk addr", chk_a1, 0);
    check("F async class addr", cls_a1, 0);
    for (int unsigned k = 0; k < NCL; k++) begin
      check($sformatf("F async sim13[%0d]", k), sim1[k], 0);
    end
    check("F async sim8[25]", sim2[NCL-1], 0);
    @(negedge clk);
    nrst = 1'b1;
    p0 = pulses;
    repeat (60) @(negedge clk);
    check("F no pulse after abort", pulses - p0, 0);
    check("F idle busy", busy1, 0);
    check("F idle q_ready", q_ready1, 0);
    @(posedge clk); #1;

    // G: a fresh query after the abort
    rom_mode = 2;
    for (int unsigned c = 0; c < NCH; c++) q_mem[c] = {$urandom, $urandom} & {$urandom, $urandom};
    run_query("G", 0, NO_POKE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
